if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, instruction byte-address width.
REQ-002 SHALL have parameter INST_W, default 64, instruction word width.
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address (8-byte aligned).
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port stall  in  1  hold PC and IF/ID register.
REQ-007 SHALL have port flush  in  1  discard in-flight fetch and redirect to new_pc.
REQ-008 SHALL have port new_pc  in  ADDR_W  flush target.
REQ-009 SHALL have port branch_flag  in  1  taken branch from decode.
REQ-010 SHALL have port branch_target  in  ADDR_W  branch destination.
REQ-011 SHALL have port pc  out  ADDR_W  fetch address to instruction ROM.
REQ-012 SHALL have port ce  out  1  ROM chip enable; 1 = enabled.
REQ-013 SHALL have port inst_i  in  INST_W  ROM data, combinational from pc.
REQ-014 SHALL have port id_pc  out  ADDR_W  registered PC to decode.
REQ-015 SHALL have port id_inst  out  INST_W  registered instruction to decode.
REQ-016 SHALL have port id_valid  out  1  id_inst is a real instruction.
REQ-017 SHALL have port fetch_cnt  out  32  count of instructions delivered to decode.

Function
REQ-018 SHALL implement FSM states IDLE and RUN; IDLE is the reset state.
REQ-019 In IDLE: ce=0, pc=RESET_PC, no IF/ID load; next edge goes to RUN unconditionally, pc unchanged.
REQ-020 In RUN: ce=1; IF/ID update by priority flush > stall > branch > sequential.
REQ-021 Flush: pc<=new_pc with bits [2:0] forced 0; id_valid<=0; id_pc, id_inst hold.
REQ-022 Stall (no flush): pc, id_pc, id_inst, id_valid, fetch_cnt hold; branch_flag ignored that cycle.
REQ-023 Branch (no flush, no stall): pc<=branch_target with [2:0] forced 0; id_valid<=0 (squash wrong-path fetch; no delay slot).
REQ-024 Sequential: pc<=pc+8 modulo 2^ADDR_W; id_pc<=pc; id_inst<=inst_i; id_valid<=1.
REQ-025 fetch_cnt SHALL increment by 1 on each edge loading id_valid=1; wraps 0xFFFFFFFF->0.
REQ-026 Flush in IDLE SHALL load pc from new_pc and still move to RUN; stall/branch in IDLE ignored.
REQ-027 Fetch latency: instruction at address A appears on id_inst one edge after pc==A in an unstalled RUN cycle.
REQ-028 pc SHALL always be 8-byte aligned; new_pc and branch_target low bits silently discarded.
REQ-029 Outputs SHALL be driven only from registers (ce, pc, id_*), except none combinational from inputs.

Reset
REQ-030 On rst low, asynchronously: state=IDLE, pc=RESET_PC, ce=0, id_pc=0, id_inst=0, id_valid=0, fetch_cnt=0.
REQ-031 Reset asserted mid-stream SHALL discard any pending branch/flush; first fetch after release is RESET_PC.
REQ-032 Reset release SHALL be followed by exactly one IDLE cycle before ce rises.

Verification
REQ-033 Reset release, no controls, 4 edges -> ce 0 then 1; pc 0,0,8,0x10; id_pc 0 then 8; id_valid 0,0,1,1.
REQ-034 Stall high 3 cycles at pc=0x10 -> pc, id_*, fetch_cnt unchanged; after release pc=0x18, id_pc=0x10.
REQ-035 branch_flag=1, branch_target=0x47 at pc=0x20 -> next pc=0x40, id_valid=0, fetch_cnt unchanged; next id_pc=0x40.
REQ-036 flush=1, stall=1, branch_flag=1, new_pc=0x100 same cycle -> pc=0x100, id_valid=0 (flush wins).
REQ-037 Force pc to 0xFFFFFFF8 via flush, run 2 edges -> pc 0x0; id_pc=0xFFFFFFF8 valid.
REQ-038 Assert rst low mid-branch, release -> all outputs reset values, one IDLE cycle, fetch resumes at RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
//==============================================================================
// Module   : if_stage
// Purpose  : Instruction-fetch stage. Keeps the fetch PC, drives the
//            instruction ROM (pc/ce), and loads the IF/ID pipeline register.
//            IF/ID updates follow this priority: flush, stall, branch,
//            sequential.
// Revision : 1.0 - initial release
//
// Ports
//   clk           in   1       single clock, rising edge
//   rst           in   1       asynchronous reset, active low
//   stall         in   1       hold PC and IF/ID register
//   flush         in   1       drop in-flight fetch, redirect to new_pc
//   new_pc        in   ADDR_W  flush target (low 3 bits ignored)
//   branch_flag   in   1       taken branch from decode
//   branch_target in   ADDR_W  branch destination (low 3 bits ignored)
//   pc            out  ADDR_W  fetch address to instruction ROM
//   ce            out  1       ROM chip enable
//   inst_i        in   INST_W  ROM data, combinational from pc
//   id_pc         out  ADDR_W  registered PC to decode
//   id_inst       out  INST_W  registered instruction to decode
//   id_valid      out  1       id_inst holds a real instruction
//   fetch_cnt     out  32      count of instructions delivered to decode
//==============================================================================
`default_nettype none

module if_stage #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INST_W   = 64,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  input  logic [INST_W-1:0] inst_i,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_valid,
  output logic [31:0]       fetch_cnt
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(8);

  // Instruction words are 8 bytes, so every fetch address is forced onto an
  // 8-byte boundary; any low bits supplied by the redirect sources are dropped.
  function automatic logic [ADDR_W-1:0] align8(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:3], 3'b000};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pc        <= align8(RESET_PC);
      ce        <= 1'b0;
      id_pc     <= '0;
      id_inst   <= '0;
      id_valid  <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      case (state)
        // One dead cycle after reset so the ROM sees a stable address before
        // ce rises. Only a flush acts here: it retargets the first fetch.
        IDLE: begin
          state <= RUN;
          ce    <= 1'b1;
          if (flush) begin
            pc <= align8(new_pc);
          end
        end

        RUN: begin
          ce <= 1'b1;
          if (flush) begin
            // id_pc/id_inst are left alone; id_valid=0 marks them as dead.
            pc       <= align8(new_pc);
            id_valid <= 1'b0;
          end else if (stall) begin
            // Everything holds, including any pending branch request.
          end else if (branch_flag) begin
            // No delay slot: the word fetched this cycle is on the wrong path.
            pc       <= align8(branch_target);
            id_valid <= 1'b0;
          end else begin
            pc        <= pc + PC_STEP;
            id_pc     <= pc;
            id_inst   <= inst_i;
            id_valid  <= 1'b1;
            fetch_cnt <= fetch_cnt + 32'd1;
          end
        end

        default: begin
          state <= IDLE;
          ce    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
//==============================================================================
// Module   : tb_if_stage
// Purpose  : Directed self-checking bench for if_stage. The ROM model returns
//            {~addr, addr} so every fetched word identifies its address.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic        ce;
  logic [63:0] inst_i;
  logic [31:0] id_pc;
  logic [63:0] id_inst;
  logic        id_valid;
  logic [31:0] fetch_cnt;

  int passed = 0;
  int total  = 0;

  if_stage #(
    .ADDR_W  (32),
    .INST_W  (64),
    .RESET_PC(32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .pc           (pc),
    .ce           (ce),
    .inst_i       (inst_i),
    .id_pc        (id_pc),
    .id_inst      (id_inst),
    .id_valid     (id_valid),
    .fetch_cnt    (fetch_cnt)
  );

  always #5 clk = ~clk;

  assign inst_i = {~pc, pc};

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_controls();
    stall         = 1'b0;
    flush         = 1'b0;
    new_pc        = 32'h0;
    branch_flag   = 1'b0;
    branch_target = 32'h0;
  endtask

  // Reset values, then the first fetches after release.
  task automatic test_reset();
    clear_controls();
    rst = 1'b0;
    tick();
    tick();
    total++; if (pc !== 32'h0) $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); else passed++;
    total++; if (ce !== 1'b0) $display("FAIL reset_ce: got %b expected %b", ce, 1'b0); else passed++;
    total++; if (id_pc !== 32'h0) $display("FAIL reset_id_pc: got %h expected %h", id_pc, 32'h0); else passed++;
    total++; if (id_inst !== 64'h0) $display("FAIL reset_id_inst: got %h expected %h", id_inst, 64'h0); else passed++;
    total++; if (id_valid !== 1'b0) $display("FAIL reset_id_valid: got %b expected %b", id_valid, 1'b0); else passed++;
    total++; if (fetch_cnt !== 32'h0) $display("FAIL reset_cnt: got %0d expected %0d", fetch_cnt, 0); else passed++;
    rst = 1'b1;
    tick(); // IDLE -> RUN
    total++; if (ce !== 1'b1) $display("FAIL run_ce: got %b expected %b", ce, 1'b1); else passed++;
    total++; if (pc !== 32'h0) $display("FAIL idle_pc: got %h expected %h", pc, 32'h0); else passed++;
    total++; if (id_valid !== 1'b0) $display("FAIL idle_valid: got %b expected %b", id_valid, 1'b0); else passed++;
    tick();
    total++; if (pc !== 32'h8) $display("FAIL seq1_pc: got %h expected %h", pc, 32'h8); else passed++;
    total++; if (id_pc !== 32'h0) $display("FAIL seq1_id_pc: got %h expected %h", id_pc, 32'h0); else passed++;
    total++; if (id_inst !== 64'hFFFFFFFF_00000000) $display("FAIL seq1_id_inst: got %h expected %h", id_inst, 64'hFFFFFFFF_00000000); else passed++;
    total++; if (id_valid !== 1'b1) $display("FAIL seq1_valid: got %b expected %b", id_valid, 1'b1); else passed++;
    total++; if (fetch_cnt !== 32'd1) $display("FAIL seq1_cnt: got %0d expected %0d", fetch_cnt, 1); else passed++;
    tick();
    total++; if (pc !== 32'h10) $display("FAIL seq2_pc: got %h expected %h", pc, 32'h10); else passed++;
    total++; if (id_pc !== 32'h8) $display("FAIL seq2_id_pc: got %h expected %h", id_pc, 32'h8); else passed++;
    total++; if (fetch_cnt !== 32'd2) $display("FAIL seq2_cnt: got %0d expected %0d", fetch_cnt, 2); else passed++;
  endtask

  // Three stalled cycles at pc=0x10 hold everything.
  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (pc !== 32'h10) $display("FAIL stall_pc[%0d]: got %h expected %h", i, pc, 32'h10); else passed++;
      total++; if (id_pc !== 32'h8 || id_valid !== 1'b1) $display("FAIL stall_id[%0d]: got %h/%b expected %h/%b", i, id_pc, id_valid, 32'h8, 1'b1); else passed++;
      total++; if (fetch_cnt !== 32'd2) $display("FAIL stall_cnt[%0d]: got %0d expected %0d", i, fetch_cnt, 2); else passed++;
    end
    stall = 1'b0;
    tick();
    total++; if (pc !== 32'h18) $display("FAIL unstall_pc: got %h expected %h", pc, 32'h18); else passed++;
    total++; if (id_pc !== 32'h10) $display("FAIL unstall_id_pc: got %h expected %h", id_pc, 32'h10); else passed++;
    total++; if (id_inst !== 64'hFFFFFFEF_00000010) $display("FAIL unstall_id_inst: got %h expected %h", id_inst, 64'hFFFFFFEF_00000010); else passed++;
    total++; if (fetch_cnt !== 32'd3) $display("FAIL unstall_cnt: got %0d expected %0d", fetch_cnt, 3); else passed++;
  endtask

  // Taken branch at pc=0x20 to unaligned 0x47, then branch masked by stall.
  task automatic test_branch();
    tick(); // pc 0x18 -> 0x20
    total++; if (pc !== 32'h20) $display("FAIL pre_branch_pc: got %h expected %h", pc, 32'h20); else passed++;
    branch_flag   = 1'b1;
    branch_target = 32'h47;
    tick();
    total++; if (pc !== 32'h40) $display("FAIL branch_pc: got %h expected %h", pc, 32'h40); else passed++;
    total++; if (id_valid !== 1'b0) $display("FAIL branch_valid: got %b expected %b", id_valid, 1'b0); else passed++;
    total++; if (fetch_cnt !== 32'd4) $display("FAIL branch_cnt: got %0d expected %0d", fetch_cnt, 4); else passed++;
    branch_flag = 1'b0;
    tick();
    total++; if (id_pc !== 32'h40 || id_valid !== 1'b1) $display("FAIL post_branch_id: got %h/%b expected %h/%b", id_pc, id_valid, 32'h40, 1'b1); else passed++;
    total++; if (pc !== 32'h48) $display("FAIL post_branch_pc: got %h expected %h", pc, 32'h48); else passed++;
    stall         = 1'b1;
    branch_flag   = 1'b1;
    branch_target = 32'h200;
    tick();
    total++; if (pc !== 32'h48 || id_valid !== 1'b1) $display("FAIL stall_branch: got %h/%b expected %h/%b", pc, id_valid, 32'h48, 1'b1); else passed++;
    clear_controls();
    tick();
    total++; if (pc !== 32'h50 || id_pc !== 32'h48) $display("FAIL stall_branch_rel: got %h/%h expected %h/%h", pc, id_pc, 32'h50, 32'h48); else passed++;
    total++; if (fetch_cnt !== 32'd6) $display("FAIL stall_branch_cnt: got %0d expected %0d", fetch_cnt, 6); else passed++;
  endtask

  // Flush beats stall and branch in the same cycle.
  task automatic test_flush_priority();
    flush         = 1'b1;
    stall         = 1'b1;
    branch_flag   = 1'b1;
    new_pc        = 32'h100;
    branch_target = 32'h200;
    tick();
    total++; if (pc !== 32'h100) $display("FAIL flush_pc: got %h expected %h", pc, 32'h100); else passed++;
    total++; if (id_valid !== 1'b0) $display("FAIL flush_valid: got %b expected %b", id_valid, 1'b0); else passed++;
    total++; if (id_pc !== 32'h48) $display("FAIL flush_id_hold: got %h expected %h", id_pc, 32'h48); else passed++;
    total++; if (fetch_cnt !== 32'd6) $display("FAIL flush_cnt: got %0d expected %0d", fetch_cnt, 6); else passed++;
    clear_controls();
    tick();
    total++; if (pc !== 32'h108 || id_pc !== 32'h100 || id_valid !== 1'b1) $display("FAIL post_flush: got %h/%h/%b expected %h/%h/%b", pc, id_pc, id_valid, 32'h108, 32'h100, 1'b1); else passed++;
  endtask

  // PC wraps from 0xFFFFFFF8 to 0.
  task automatic test_wrap();
    flush  = 1'b1;
    new_pc = 32'hFFFF_FFFF;
    tick();
    total++; if (pc !== 32'hFFFF_FFF8) $display("FAIL wrap_flush_pc: got %h expected %h", pc, 32'hFFFF_FFF8); else passed++;
    clear_controls();
    tick();
    total++; if (pc !== 32'h0) $display("FAIL wrap_pc: got %h expected %h", pc, 32'h0); else passed++;
    total++; if (id_pc !== 32'hFFFF_FFF8 || id_valid !== 1'b1) $display("FAIL wrap_id: got %h/%b expected %h/%b", id_pc, id_valid, 32'hFFFF_FFF8, 1'b1); else passed++;
    total++; if (id_inst !== 64'h00000007_FFFFFFF8) $display("FAIL wrap_inst: got %h expected %h", id_inst, 64'h00000007_FFFFFFF8); else passed++;
    tick();
    total++; if (pc !== 32'h8 || id_pc !== 32'h0) $display("FAIL wrap_next: got %h/%h expected %h/%h", pc, id_pc, 32'h8, 32'h0); else passed++;
    total++; if (fetch_cnt !== 32'd9) $display("FAIL wrap_cnt: got %0d expected %0d", fetch_cnt, 9); else passed++;
  endtask

  // Reset asserted between edges while a branch is pending.
  task automatic test_reset_mid_branch();
    branch_flag   = 1'b1;
    branch_target = 32'h300;
    rst = 1'b0;
    #1;
    total++; if (pc !== 32'h0 || ce !== 1'b0) $display("FAIL async_rst: got %h/%b expected %h/%b", pc, ce, 32'h0, 1'b0); else passed++;
    total++; if (id_pc !== 32'h0 || id_inst !== 64'h0 || id_valid !== 1'b0) $display("FAIL async_rst_id: got %h/%h/%b expected 0/0/0", id_pc, id_inst, id_valid); else passed++;
    total++; if (fetch_cnt !== 32'h0) $display("FAIL async_rst_cnt: got %0d expected %0d", fetch_cnt, 0); else passed++;
    tick();
    rst = 1'b1;
    tick(); // IDLE cycle; branch_flag still high and must be ignored
    total++; if (ce !== 1'b1 || pc !== 32'h0) $display("FAIL rst_idle: got %b/%h expected %b/%h", ce, pc, 1'b1, 32'h0); else passed++;
    clear_controls();
    tick();
    total++; if (pc !== 32'h8 || id_pc !== 32'h0 || id_valid !== 1'b1) $display("FAIL rst_resume: got %h/%h/%b expected %h/%h/%b", pc, id_pc, id_valid, 32'h8, 32'h0, 1'b1); else passed++;
    total++; if (fetch_cnt !== 32'd1) $display("FAIL rst_resume_cnt: got %0d expected %0d", fetch_cnt, 1); else passed++;
  endtask

  // Flush during the IDLE cycle retargets the first fetch.
  task automatic test_idle_flush();
    rst = 1'b0;
    tick();
    rst    = 1'b1;
    flush  = 1'b1;
    new_pc = 32'h83;
    tick();
    total++; if (ce !== 1'b1 || pc !== 32'h80) $display("FAIL idle_flush: got %b/%h expected %b/%h", ce, pc, 1'b1, 32'h80); else passed++;
    clear_controls();
    tick();
    total++; if (pc !== 32'h88 || id_pc !== 32'h80 || id_valid !== 1'b1) $display("FAIL idle_flush_run: got %h/%h/%b expected %h/%h/%b", pc, id_pc, id_valid, 32'h88, 32'h80, 1'b1); else passed++;
  endtask

  initial begin
    test_reset();
    test_stall();
    test_branch();
    test_flush_priority();
    test_wrap();
    test_reset_mid_branch();
    test_idle_flush();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
